// File: rtl/param_loader_uart_if.sv
// rtl/param_loader_uart_if.sv - parameter set and status strobes from the UART parameter loader
interface param_loader_uart_if;
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
    logic        rx_done;
    logic        csum_err;
    logic        frame_err;
    logic        busy;

    modport master (
        output per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl,
        output rx_done, csum_err, frame_err, busy
    );

    modport slave (
        input per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl,
        input rx_done, csum_err, frame_err, busy
    );
endinterface

// File: rtl/param_loader_uart.sv
// rtl/param_loader_uart.sv - 8N1 UART receiver and checksummed pulse-parameter packet decoder
module param_loader_uart #(
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         BAUD         = 115_200,
    parameter int         CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int         TIMEOUT_CLKS = 16 * CLKS_PER_BIT,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rxd,
    param_loader_uart_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [4:0]    IDX_LAST  = 5'd17;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {PK_IDLE, PK_PAYLOAD, PK_CHECK} pk_state_t;

    rx_state_t     rx_state, rx_next;
    pk_state_t     pk_state, pk_next;
    logic          rxd_meta, rxd_sync, rxd_prev;
    logic          start_edge, bit_tick, byte_valid, stop_err;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic [TW-1:0] idle_cnt;
    logic          timeout;
    logic [4:0]    idx;
    logic [7:0]    xsum;
    logic [7:0]    shadow [17];
    logic          bl_shadow;
    logic          done_set, cerr_set, ferr_set;

    // rxd is asynchronous to clk; rxd_prev gives the edge detector its previous sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign start_edge = rxd_prev & ~rxd_sync;

    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        bit_tick   = (rx_state == RX_START) ? (bit_cnt == HALF_LAST) : (bit_cnt == BIT_LAST);
        case (rx_state)
            RX_IDLE:  if (start_edge) rx_next = RX_START;
            RX_START: if (bit_tick) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (bit_tick) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rxd_sync;
                    stop_err   = ~rxd_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || bit_tick) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (rx_state == RX_START) begin
                bit_idx <= '0;
            end else if (rx_state == RX_DATA && bit_tick) begin
                bit_idx  <= bit_idx + 1'b1;
                rx_shift <= {rxd_sync, rx_shift[7:1]};
            end
        end
    end

    // Inter-byte timeout only runs while the receiver sits idle inside a packet
    assign timeout = (pk_state != PK_IDLE) && (rx_state == RX_IDLE) && !start_edge
                     && (idle_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (pk_state == PK_IDLE || rx_state != RX_IDLE || start_edge || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        pk_next  = pk_state;
        done_set = 1'b0;
        cerr_set = 1'b0;
        ferr_set = 1'b0;
        case (pk_state)
            PK_IDLE: begin
                if (byte_valid && rx_shift == SYNC_BYTE) pk_next = PK_PAYLOAD;
            end
            PK_PAYLOAD: begin
                if (stop_err || timeout) begin
                    ferr_set = 1'b1;
                    pk_next  = PK_IDLE;
                end else if (byte_valid && idx == IDX_LAST) begin
                    pk_next = PK_CHECK;
                end
            end
            PK_CHECK: begin
                if (stop_err || timeout) begin
                    ferr_set = 1'b1;
                    pk_next  = PK_IDLE;
                end else if (byte_valid) begin
                    done_set = (rx_shift == xsum);
                    cerr_set = (rx_shift != xsum);
                    pk_next  = PK_IDLE;
                end
            end
            default: pk_next = PK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pk_state <= PK_IDLE;
            idx      <= '0;
            xsum     <= '0;
        end else begin
            pk_state <= pk_next;
            if (pk_state == PK_IDLE && pk_next == PK_PAYLOAD) begin
                idx  <= '0;
                xsum <= '0;
            end else if (pk_state == PK_PAYLOAD && byte_valid) begin
                idx  <= idx + 1'b1;
                xsum <= xsum ^ rx_shift;
            end
        end
    end

    // bl only needs bit 0 of the last payload byte, so that byte is not kept whole
    always_ff @(posedge clk) begin
        if (pk_state == PK_PAYLOAD && byte_valid) begin
            if (idx == IDX_LAST) begin
                bl_shadow <= rx_shift[0];
            end else begin
                shadow[idx] <= rx_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.per       <= 32'h0001_0000;
            bus.p1wid     <= 16'd30;
            bus.del       <= 16'd200;
            bus.p2wid     <= 16'd30;
            bus.nut_w     <= 8'd50;
            bus.nut_d     <= 16'd300;
            bus.cp        <= 8'd3;
            bus.p_bl      <= 8'd50;
            bus.p_bl_off  <= 16'd100;
            bus.bl        <= 1'b1;
            bus.rx_done   <= 1'b0;
            bus.csum_err  <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.rx_done   <= done_set;
            bus.csum_err  <= cerr_set;
            bus.frame_err <= ferr_set;
            if (done_set) begin
                bus.per      <= {shadow[0], shadow[1], shadow[2], shadow[3]};
                bus.p1wid    <= {shadow[4], shadow[5]};
                bus.del      <= {shadow[6], shadow[7]};
                bus.p2wid    <= {shadow[8], shadow[9]};
                bus.nut_w    <= shadow[10];
                bus.nut_d    <= {shadow[11], shadow[12]};
                bus.cp       <= shadow[13];
                bus.p_bl     <= shadow[14];
                bus.p_bl_off <= {shadow[15], shadow[16]};
                bus.bl       <= bl_shadow;
            end
        end
    end

    assign bus.busy = (pk_state != PK_IDLE);
endmodule

// File: tb/tb_param_loader_uart.sv
// tb/tb_param_loader_uart.sv - randomized self-checking bench for param_loader_uart
module tb_param_loader_uart;
    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 62_500;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int TIMEOUT = 16 * CPB;

    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [7:0]  nut_w;
        logic [15:0] nut_d;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic        bl;
    } params_t;

    localparam params_t DEF = '{32'h0001_0000, 16'd30, 16'd200, 16'd30, 8'd50,
                                16'd300, 8'd3, 8'd50, 16'd100, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1;

    param_loader_uart_if bus();

    param_loader_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_done = 0, n_cerr = 0, n_ferr = 0;
    int multi_viol = 0, stable_viol = 0;
    logic [144:0] prev_out;
    logic [7:0] pkt [$];
    params_t exp_p;

    // Passive observers: strobe counts and the "outputs move only with rx_done" rule
    always @(negedge clk) begin
        logic [144:0] cur;
        cur = {bus.per, bus.p1wid, bus.del, bus.p2wid, bus.nut_w, bus.nut_d,
               bus.cp, bus.p_bl, bus.p_bl_off, bus.bl};
        if (!reset) begin
            n_done += int'(bus.rx_done);
            n_cerr += int'(bus.csum_err);
            n_ferr += int'(bus.frame_err);
            if (int'(bus.rx_done) + int'(bus.csum_err) + int'(bus.frame_err) > 1) multi_viol++;
            if (!bus.rx_done && cur !== prev_out) stable_viol++;
        end
        prev_out = cur;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_params(input string tag, input params_t e);
        check({tag, ".per"}, bus.per, e.per);
        check({tag, ".p1wid"}, 32'(bus.p1wid), 32'(e.p1wid));
        check({tag, ".del"}, 32'(bus.del), 32'(e.del));
        check({tag, ".p2wid"}, 32'(bus.p2wid), 32'(e.p2wid));
        check({tag, ".nut_w"}, 32'(bus.nut_w), 32'(e.nut_w));
        check({tag, ".nut_d"}, 32'(bus.nut_d), 32'(e.nut_d));
        check({tag, ".cp"}, 32'(bus.cp), 32'(e.cp));
        check({tag, ".p_bl"}, 32'(bus.p_bl), 32'(e.p_bl));
        check({tag, ".p_bl_off"}, 32'(bus.p_bl_off), 32'(e.p_bl_off));
        check({tag, ".bl"}, 32'(bus.bl), 32'(e.bl));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!stop_ok) repeat (2 * CPB) @(negedge clk);
    endtask

    // Packet = SYNC, big-endian fields in wire order, XOR of payload; bl's spare bits are random
    task automatic build(input params_t p, input logic [7:0] ck_flip);
        logic [143:0] v;
        logic [7:0] b, ck;
        v = {p.per, p.p1wid, p.del, p.p2wid, p.nut_w, p.nut_d, p.cp, p.p_bl,
             p.p_bl_off, 7'($urandom), p.bl};
        pkt = {};
        pkt.push_back(8'hA5);
        ck = 8'h00;
        for (int i = 0; i < 18; i++) begin
            b = v[143 - 8 * i -: 8];
            pkt.push_back(b);
            ck ^= b;
        end
        pkt.push_back(ck ^ ck_flip);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    function automatic params_t rand_params();
        params_t p;
        p = {$urandom, $urandom, $urandom, $urandom, $urandom, 17'($urandom)};
        return p;
    endfunction

    initial begin
        params_t p, t2;
        int d0, c0, f0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        exp_p = DEF;
        check_params("reset", exp_p);
        check("reset.busy", 32'(bus.busy), 0);
        check("reset.strobes", 32'(n_done + n_cerr + n_ferr), 0);

        t2 = '{32'h0003_0D40, 16'd40, 16'd400, 16'd80, 8'd0, 16'd0, 8'd1, 8'd20, 16'd300, 1'b0};
        d0 = n_done;
        build(t2, 8'h00);
        send_pkt();
        exp_p = t2;
        check("good.rx_done", 32'(n_done - d0), 1);
        check_params("good", exp_p);
        repeat (3 * CPB) @(negedge clk);
        check_params("good.stable", exp_p);

        d0 = n_done; c0 = n_cerr;
        build(t2 ^ 145'h1, 8'h01);
        send_pkt();
        check("badck.csum_err", 32'(n_cerr - c0), 1);
        check("badck.rx_done", 32'(n_done - d0), 0);
        check_params("badck", exp_p);

        f0 = n_ferr;
        send_byte(8'h3C, 1'b0);
        check("idle_stop.frame_err", 32'(n_ferr - f0), 0);

        p = rand_params();
        build(p, 8'h00);
        for (int i = 0; i < 6; i++) send_byte(pkt[i], 1'b1);
        send_byte(pkt[6], 1'b0);
        check("stop.frame_err", 32'(n_ferr - f0), 1);
        check("stop.busy", 32'(bus.busy), 0);
        check_params("stop.kept", exp_p);
        d0 = n_done;
        send_pkt();
        exp_p = p;
        check("stop.recover", 32'(n_done - d0), 1);
        check_params("stop.recover", exp_p);

        f0 = n_ferr;
        p = rand_params();
        build(p, 8'h00);
        for (int i = 0; i < 8; i++) send_byte(pkt[i], 1'b1);
        check("to.busy_before", 32'(bus.busy), 1);
        repeat (TIMEOUT + 2 * CPB) @(negedge clk);
        check("to.frame_err", 32'(n_ferr - f0), 1);
        check("to.busy", 32'(bus.busy), 0);
        d0 = n_done;
        send_pkt();
        exp_p = p;
        check("to.recover", 32'(n_done - d0), 1);
        check_params("to.recover", exp_p);

        p = rand_params();
        build(p, 8'h00);
        for (int i = 0; i < 11; i++) send_byte(pkt[i], 1'b1);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        exp_p = DEF;
        check_params("rst_mid", exp_p);
        check("rst_mid.busy", 32'(bus.busy), 0);
        p = rand_params();
        p.cp = 8'd7;
        d0 = n_done;
        build(p, 8'h00);
        send_pkt();
        exp_p = p;
        check("rst_mid.rx_done", 32'(n_done - d0), 1);
        check_params("rst_mid.cp7", exp_p);

        d0 = n_done; c0 = n_cerr; f0 = n_ferr;
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch.strobes", 32'((n_done - d0) + (n_cerr - c0) + (n_ferr - f0)), 0);
        check("glitch.busy", 32'(bus.busy), 0);

        p = rand_params();
        p.p1wid = 16'hA5A5;
        p.cp = 8'hA5;
        p.p_bl = 8'hA5;
        d0 = n_done;
        build(p, 8'h00);
        send_pkt();
        exp_p = p;
        check("a5.rx_done", 32'(n_done - d0), 1);
        check_params("a5", exp_p);

        d0 = n_done;
        build(rand_params(), 8'h00);
        foreach (pkt[i]) send_byte(pkt[i], 1'b1);
        p = rand_params();
        build(p, 8'h00);
        send_pkt();
        exp_p = p;
        check("b2b.rx_done", 32'(n_done - d0), 2);
        check_params("b2b", exp_p);

        for (int k = 0; k < 4; k++) begin
            bit bad;
            bad = 1'($urandom_range(0, 1));
            p = rand_params();
            d0 = n_done; c0 = n_cerr;
            build(p, bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            send_pkt();
            if (!bad) exp_p = p;
            check("rnd.rx_done", 32'(n_done - d0), bad ? 0 : 1);
            check("rnd.csum_err", 32'(n_cerr - c0), bad ? 1 : 0);
            check_params("rnd", exp_p);
        end

        check("strobe_exclusive", 32'(multi_viol), 0);
        check("outputs_only_on_rx_done", 32'(stable_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
